// File: rtl/bcd_display_driver.sv
// Binary-to-BCD display stage: sequential double-dabble converter plus a multiplexed 5-digit 7-segment scanner.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module bcd_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] c_in,
  output logic [19:0] bcd_out,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [4:0]  an,
  output logic [1:0]  fsm_state
);

  // Handshake: bcd_valid is a one-cycle strobe with no ready/backpressure; bcd_out holds until the next strobe.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] SCAN_TERM = PW'(SCAN_DIV - 1);

  conv_state_t state;
  logic [15:0] last_val;
  logic [15:0] cap;
  logic [35:0] shreg;
  logic [35:0] shreg_adj;
  logic [3:0]  cnt;

  logic [PW-1:0] prescaler;
  logic [2:0]    digit_idx;
  logic [3:0]    cur_nib;
  logic          blank;
  logic [6:0]    seg_next;
  logic [4:0]    an_next;

  assign fsm_state = state;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Add-3 correction on every BCD column before the shift.
  always_comb begin
    shreg_adj = shreg;
    for (int i = 0; i < 5; i++) begin
      if (shreg[16 + 4*i +: 4] >= 4'd5)
        shreg_adj[16 + 4*i +: 4] = shreg[16 + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_val  <= 16'd0;
      cap       <= 16'd0;
      shreg     <= 36'd0;
      cnt       <= 4'd0;
      bcd_out   <= 20'd0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (c_in != last_val) begin
            shreg <= {20'd0, c_in};
            cap   <= c_in;
            cnt   <= 4'd0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= {shreg_adj[34:0], 1'b0};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15)
            state <= DONE;
        end
        DONE: begin
          bcd_out   <= shreg[35:16];
          last_val  <= cap;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cur_nib = 4'd0;
    an_next = 5'h1F;
    case (digit_idx)
      3'd0: begin cur_nib = bcd_out[3:0];   an_next = 5'h1E; end
      3'd1: begin cur_nib = bcd_out[7:4];   an_next = 5'h1D; end
      3'd2: begin cur_nib = bcd_out[11:8];  an_next = 5'h1B; end
      3'd3: begin cur_nib = bcd_out[15:12]; an_next = 5'h17; end
      3'd4: begin cur_nib = bcd_out[19:16]; an_next = 5'h0F; end
      default: begin cur_nib = 4'd0; an_next = 5'h1F; end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked when it and every digit above it are zero; the units digit is never blanked.
  always_comb begin
    blank = 1'b0;
    case (digit_idx)
      3'd1:    blank = (bcd_out[19:4]  == 16'd0);
      3'd2:    blank = (bcd_out[19:8]  == 12'd0);
      3'd3:    blank = (bcd_out[19:12] == 8'd0);
      3'd4:    blank = (bcd_out[19:16] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  always_comb begin
    seg_next = blank ? 7'h7F : decode(cur_nib);
  end

  // digit_idx names the digit presented at the next terminal count, so the first tick shows the units.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      digit_idx <= 3'd0;
      seg       <= 7'h7F;
      an        <= 5'h1F;
    end else if (prescaler == SCAN_TERM) begin
      prescaler <= '0;
      an        <= an_next;
      seg       <= seg_next;
      digit_idx <= (digit_idx == 3'd4) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: scoreboard on bcd_valid strobes plus scan/segment checks.
module tb_bcd_display_driver;

  localparam int SCAN_DIV = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic        clk;
  logic        reset;
  logic [15:0] c_in;
  logic [19:0] bcd_out;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [4:0]  an;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int cyc      = 0;

  logic [19:0] exp_q[$];
  int          exp_cyc_q[$];

  bcd_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .c_in(c_in),
    .bcd_out(bcd_out),
    .bcd_valid(bcd_valid),
    .seg(seg),
    .an(an),
    .fsm_state(fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected value and its cycle.
  always @(negedge clk) begin
    if (bcd_valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(bcd_out), -1);
      end else begin
        check("bcd_value", int'(bcd_out), int'(exp_q.pop_front()));
        check("bcd_latency", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic wait_pulses(input int target);
    int t = 0;
    while (n_pulses < target && t < 80) begin
      @(negedge clk);
      t++;
    end
    check("pulse_arrived", int'(n_pulses >= target), 1);
  endtask

  task automatic convert(input logic [15:0] v, input logic [19:0] exp_bcd);
    int target;
    @(posedge clk);
    #1;
    target = n_pulses + 1;
    c_in = v;
    exp_q.push_back(exp_bcd);
    exp_cyc_q.push_back(cyc + 18);
    wait_pulses(target);
  endtask

  // segs packs the expected pattern per digit as {d4,d3,d2,d1,d0}.
  task automatic check_scan(input string tag, input logic [34:0] segs);
    logic [24:0] an_tab;
    int t;
    int dd;
    an_tab = {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E};
    t = 0;
    while (an === 5'h1E && t < 100) begin @(negedge clk); t++; end
    while (an !== 5'h1E && t < 100) begin @(negedge clk); t++; end
    check({tag, "_sync"}, int'(an), 5'h1E);
    if (an !== 5'h1E) return;
    for (int d = 0; d < 6; d++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (!(d == 0 && c == 0)) @(negedge clk);
        dd = d % 5;
        check({tag, "_an"}, int'(an), int'(an_tab[dd*5 +: 5]));
        check({tag, "_seg"}, int'(seg), int'(segs[dd*7 +: 7]));
      end
    end
  endtask

  initial begin
    int base;
    reset = 1'b1;
    c_in  = 16'd0;

    // Reset state and first scan tick
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bcd_out", int'(bcd_out), 0);
    check("rst_bcd_valid", int'(bcd_valid), 0);
    check("rst_seg", int'(seg), 7'h7F);
    check("rst_an", int'(an), 5'h1F);
    check("rst_state", int'(fsm_state), ST_IDLE);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_tick_an", int'(an), 5'h1F);
    check("pre_tick_seg", int'(seg), 7'h7F);
    @(negedge clk);
    check("first_tick_an", int'(an), 5'h1E);
    check("first_tick_seg", int'(seg), 7'h40);

    // Conversions, including the maximum input
    convert(16'd1,     20'h00001);
    convert(16'd65535, 20'h65535);
    convert(16'd9999,  20'h09999);
    convert(16'd10,    20'h00010);

    // Full scan of 12345: digits 5,4,3,2,1
    convert(16'd12345, 20'h12345);
    check_scan("scan12345", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12});

    // Leading-zero handling for 42
    convert(16'd42, 20'h00042);
`ifdef LEADING_ZERO_BLANK_EN
    check_scan("scan42", {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
`else
    check_scan("scan42", {7'h40, 7'h40, 7'h40, 7'h19, 7'h24});
`endif

    // Input change mid-conversion: old value finishes, new one converts next
    @(posedge clk);
    #1;
    base = n_pulses;
    c_in = 16'd2;
    exp_q.push_back(20'h00002);
    exp_cyc_q.push_back(cyc + 18);
    exp_q.push_back(20'h00003);
    exp_cyc_q.push_back(cyc + 36);
    repeat (6) @(posedge clk);
    #1 c_in = 16'd3;
    wait_pulses(base + 2);
    repeat (60) @(negedge clk);
    check("no_extra_pulse", n_pulses, base + 2);

    // Reset mid-SHIFT aborts without a pulse, then the value reconverts
    @(posedge clk);
    #1 c_in = 16'd500;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_state", int'(fsm_state), ST_IDLE);
    check("midrst_bcd_out", int'(bcd_out), 0);
    check("midrst_bcd_valid", int'(bcd_valid), 0);
    check("midrst_an", int'(an), 5'h1F);
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = n_pulses;
    exp_q.push_back(20'h00500);
    exp_cyc_q.push_back(cyc + 18);
    wait_pulses(base + 1);
    check("final_bcd_out", int'(bcd_out), 20'h00500);

    repeat (30) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
